// File: rtl/mul18_sched_pkg.sv
// Shared constants and helpers for the multiplier scheduler slice.
package mul18_sched_pkg;

    localparam int MUL_W   = 18;
    localparam int PROD_W  = 36;
    localparam int MAX_REQ = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Tag width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin pick: first set bit of req at or after ptr, wrapping at n.
    // The caller guarantees ptr < n, so a single subtraction folds the index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [3:0]         ptr,
                                      input int                 n);
        pick_t res;
        int    cand;
        logic  hit;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand      = int'(ptr) + k;
            cand      = (cand >= n) ? (cand - n) : cand;
            hit       = (k < n) && !res.found && req[cand[3:0]];
            res.idx   = hit ? cand[3:0] : res.idx;
            res.found = res.found | hit;
        end
        return res;
    endfunction

endpackage

// File: rtl/mul18_sched_mul18.sv
// Registered 18x18 signed multiplier: operand stage (en0/en1) then product stage (en2).
module mul18
    import mul18_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en0_i,
    input  logic                     en1_i,
    input  logic                     en2_i,
    input  logic signed [MUL_W-1:0]  a_i,
    input  logic signed [MUL_W-1:0]  b_i,
    output logic signed [PROD_W-1:0] p_o
);

    logic signed [MUL_W-1:0]  a_q;
    logic signed [MUL_W-1:0]  b_q;
    logic signed [PROD_W-1:0] p_q;
    logic signed [PROD_W-1:0] prod_s;

    // Full-precision signed product of the held operands (both sides sign-extend).
    assign prod_s = PROD_W'(a_q) * PROD_W'(b_q);

    // Operand A capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
        end else if (en0_i) begin
            a_q <= a_i;
        end
    end

    // Operand B capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q <= '0;
        end else if (en1_i) begin
            b_q <= b_i;
        end
    end

    // Product register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= '0;
        end else if (en2_i) begin
            p_q <= prod_s;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mul18_sched.sv
// Round-robin scheduler feeding one shared registered 18x18 multiplier as a
// stallable two-stage pipeline; products come back tagged with the requester id.
module mul18_sched
    import mul18_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*MUL_W-1:0]    req_a,
    input  logic [NREQ*MUL_W-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic signed [PROD_W-1:0] rsp_x,
    output logic                     idle
);

    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic [ID_W-1:0] id1_q, id1_d;
    logic [ID_W-1:0] id2_q, id2_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic                    adv1_s, adv2_s;
    logic                    transfer_s;
    logic                    en2_s;
    pick_t                   pick_s;
    logic [ID_W-1:0]         gnt_s;
    logic [NREQ-1:0]         req_ready_s;
    logic [MAX_REQ-1:0]      req_vec_s;
    logic [3:0]              ptr_w_s;
    logic signed [MUL_W-1:0] a_sel_s;
    logic signed [MUL_W-1:0] b_sel_s;

    // Grant selection and handshake; ready is held low while reset is asserted.
    always_comb begin
        req_vec_s             = '0;
        req_vec_s[NREQ-1:0]   = req_valid;
        ptr_w_s               = '0;
        ptr_w_s[ID_W-1:0]     = ptr_q;
        adv2_s                = !v2_q || rsp_ready;
        adv1_s                = !v1_q || adv2_s;
        pick_s                = rr_pick(req_vec_s, ptr_w_s, NREQ);
        gnt_s                 = ID_W'(pick_s.idx);
        req_ready_s           = '0;
        if (reset_n && adv1_s && pick_s.found) begin
            req_ready_s[gnt_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
        transfer_s = |(req_valid & req_ready_s);
        en2_s      = adv2_s && v1_q;
        a_sel_s    = req_a[gnt_s*MUL_W +: MUL_W];
        b_sel_s    = req_b[gnt_s*MUL_W +: MUL_W];
    end

    // Next-state for pointer and stage tracking; S2 takes S1 whenever it may advance.
    always_comb begin
        ptr_d = ptr_q;
        id1_d = id1_q;
        id2_d = id2_q;
        if (transfer_s) begin
            ptr_d = (gnt_s == ID_W'(NREQ - 1)) ? '0 : (gnt_s + 1'b1);
            id1_d = gnt_s;
        end else begin
            ptr_d = ptr_q;
            id1_d = id1_q;
        end
        if (en2_s) begin
            id2_d = id1_q;
        end else begin
            id2_d = id2_q;
        end
        v1_d = transfer_s || (v1_q && !adv2_s);
        v2_d = (v1_q && adv2_s) || (v2_q && !rsp_ready);
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            id1_q <= '0;
            id2_q <= '0;
            ptr_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            id1_q <= id1_d;
            id2_q <= id2_d;
            ptr_q <= ptr_d;
        end
    end

    mul18 u_mul18 (
        .clk     (clk),
        .reset_n (reset_n),
        .en0_i   (transfer_s),
        .en1_i   (transfer_s),
        .en2_i   (en2_s),
        .a_i     (a_sel_s),
        .b_i     (b_sel_s),
        .p_o     (rsp_x)
    );

    assign req_ready = req_ready_s;
    assign rsp_valid = v2_q;
    assign rsp_id    = id2_q;
    assign idle      = !v1_q && !v2_q;

endmodule

// File: tb/tb_mul18_sched.sv
// Directed bench for mul18_sched: inputs change just after the falling edge,
// outputs are sampled 1ns after the rising edge (or after the input settle).
module tb_mul18_sched;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [71:0]        req_a;
    logic [71:0]        req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic signed [35:0] rsp_x;
    logic               idle;

    int total = 0;
    int bad   = 0;

    mul18_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b);
        req_a[i*18 +: 18] = a;
        req_b[i*18 +: 18] = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
        req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
        reset_n = 1'b1; req_valid = 4'b0000;
        #1;
        total++; if (rsp_x !== 36'sd0) begin bad++; $display("FAIL rst_x: got %0d want 0", rsp_x); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL rst_id: got %0d want 0", rsp_id); end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100; set_op(2, 18'd3, 18'(-5)); #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", rsp_valid); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", idle); end
        @(negedge clk); req_valid = 4'b0000;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", rsp_id); end
        total++; if (rsp_x !== -36'sd15) begin bad++; $display("FAIL single_x: got %0d want -15", rsp_x); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_once: got %b want 0", rsp_valid); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle: got %b want 1", idle); end
    endtask

    task automatic test_extremes();
        logic [17:0]        ea[2];
        logic [17:0]        eb[2];
        logic signed [35:0] ex[2];
        ea = '{18'h20000, 18'h1FFFF};
        eb = '{18'h20000, 18'h20000};
        ex = '{36'sh4_0000_0000, -36'sd17179738112};
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            req_valid = 4'b1000; set_op(3, ea[v], eb[v]); #1;
            total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL ext_ready%0d: got %b want 1000", v, req_ready); end
            @(negedge clk); req_valid = 4'b0000;
            @(posedge clk); #1;
            total++; if (rsp_x !== ex[v]) begin bad++; $display("FAIL ext_x%0d: got %0d want %0d", v, rsp_x, ex[v]); end
            total++; if (rsp_id !== 2'd3) begin bad++; $display("FAIL ext_id%0d: got %0d want 3", v, rsp_id); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        logic signed [35:0] fp[4];
        logic [3:0]         exp_rdy;
        int                 g;
        fp = '{36'sd15, -36'sd14, -36'sd36, -36'sd66};
        @(negedge clk);
        set_op(0, 18'd5, 18'd3);     set_op(1, 18'd7, 18'(-2));
        set_op(2, 18'(-9), 18'd4);   set_op(3, 18'd11, 18'(-6));
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k != 0) @(negedge clk);
            if (k == 6) req_valid = 4'b0000;
            #1;
            exp_rdy = (k < 6) ? (4'b0001 << (k % 4)) : 4'b0000;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL fair_ready%0d: got %b want %b", k, req_ready, exp_rdy); end
            @(posedge clk); #1;
            if (k >= 1) begin
                g = (k - 1) % 4;
                total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL fair_valid%0d: got %b want 1", k, rsp_valid); end
                total++; if (rsp_id !== 2'(g)) begin bad++; $display("FAIL fair_id%0d: got %0d want %0d", k, rsp_id, g); end
                total++; if (rsp_x !== fp[g]) begin bad++; $display("FAIL fair_x%0d: got %0d want %0d", k, rsp_x, fp[g]); end
            end else begin
                total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL fair_lat: got %b want 0", rsp_valid); end
            end
        end
        @(posedge clk); #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL fair_idle: got %b want 1", idle); end
    endtask

    task automatic test_backpressure();
        logic [17:0]        ba[4];
        logic [17:0]        bb[4];
        logic               rdy_tab[11];
        logic [3:0]         er[11];
        logic               ev[11];
        logic signed [35:0] ex[11];
        int                 oi;
        ba = '{18'd2, 18'd4, 18'(-6), 18'd8};
        bb = '{18'd3, 18'(-5), 18'd7, 18'd9};
        rdy_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        er = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
               4'b0010, 4'b0010, 4'b0000, 4'b0000};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ex = '{36'sd0, 36'sd6, 36'sd6, 36'sd6, 36'sd6, 36'sd6, 36'sd6,
               -36'sd20, -36'sd42, 36'sd72, 36'sd0};
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            rsp_ready = rdy_tab[c];
            req_valid = (c <= 8) ? 4'b0010 : 4'b0000;
            oi = (c < 2) ? c : ((c <= 7) ? 2 : 3);
            set_op(1, ba[oi], bb[oi]);
            #1;
            total++; if (req_ready !== er[c]) begin bad++; $display("FAIL bp_ready%0d: got %b want %b", c, req_ready, er[c]); end
            @(posedge clk); #1;
            total++; if (rsp_valid !== ev[c]) begin bad++; $display("FAIL bp_valid%0d: got %b want %b", c, rsp_valid, ev[c]); end
            if (ev[c]) begin
                total++; if (rsp_x !== ex[c]) begin bad++; $display("FAIL bp_x%0d: got %0d want %0d", c, rsp_x, ex[c]); end
                total++; if (rsp_id !== 2'd1) begin bad++; $display("FAIL bp_id%0d: got %0d want 1", c, rsp_id); end
            end
            if (c >= 2 && c <= 6) begin
                total++; if (idle !== 1'b0) begin bad++; $display("FAIL bp_busy%0d: got %b want 0", c, idle); end
            end
        end
    endtask

    task automatic test_wrap_skip();
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 4'b0100; set_op(2, 18'd1, 18'd1); #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_pre: got %b want 0100", req_ready); end
        @(negedge clk); req_valid = 4'b0000;
        @(posedge clk); #1;
        total++; if (rsp_x !== 36'sd1) begin bad++; $display("FAIL wrap_pre_x: got %0d want 1", rsp_x); end
        @(negedge clk);
        req_valid = 4'b1001; set_op(3, 18'(-3), 18'(-3)); set_op(0, 18'd10, 18'(-10)); #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_g3: got %b want 1000", req_ready); end
        @(negedge clk); req_valid = 4'b0001; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_g0: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_id !== 2'd3) begin bad++; $display("FAIL wrap_id3: got %0d want 3", rsp_id); end
        total++; if (rsp_x !== 36'sd9) begin bad++; $display("FAIL wrap_x3: got %0d want 9", rsp_x); end
        @(negedge clk); req_valid = 4'b0000;
        @(posedge clk); #1;
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL wrap_id0: got %0d want 0", rsp_id); end
        total++; if (rsp_x !== -36'sd100) begin bad++; $display("FAIL wrap_x0: got %0d want -100", rsp_x); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 4'b0110;
        set_op(1, 18'd2, 18'd2); set_op(2, 18'd3, 18'd3); #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_g1: got %b want 0010", req_ready); end
        @(negedge clk); req_valid = 4'b0100; #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_g2: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b1001; set_op(0, 18'd6, 18'(-7)); set_op(3, 18'd5, 18'd5); #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_full: got %b want 0000", req_ready); end
        total++; if (rsp_x !== 36'sd4) begin bad++; $display("FAIL mid_x: got %0d want 4", rsp_x); end
        reset_n = 1'b0; #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_x !== 36'sd0) begin bad++; $display("FAIL mid_rst_x: got %0d want 0", rsp_x); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_rst_idle: got %b want 1", idle); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL mid_rst_id: got %0d want 0", rsp_id); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1; rsp_ready = 1'b1; #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr0: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_ghost: got %b want 0", rsp_valid); end
        @(negedge clk); req_valid = 4'b0000;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_post_valid: got %b want 1", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL mid_post_id: got %0d want 0", rsp_id); end
        total++; if (rsp_x !== -36'sd42) begin bad++; $display("FAIL mid_post_x: got %0d want -42", rsp_x); end
        @(posedge clk); #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_post_idle: got %b want 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
